actuator_spike_scheduler: RTL and testbench
===========================================

ACTUATOR_SPIKE_SCHEDULER -- requirements
Module: actuator_spike_scheduler

Interface
REQ-001 Parameters SHALL be: NCH, default 4, number of spike requester channels.
REQ-002 Parameters SHALL be: CNT_W, default 4, width of per-channel pending counter.
REQ-003 Parameters SHALL be: GAP, default 2, idle cycles enforced after each issued spike (0 allowed).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 spike_req  input  NCH  per-channel spike pulses, sampled every edge.
REQ-007 enable  input  1  permits issuing; counting continues when low.
REQ-008 drv_ready  input  1  downstream actuator driver accepts a spike.
REQ-009 ovf_clr  input  1  clears all sticky overflow flags.
REQ-010 spike_out  output  1  single-cycle spike to the shared actuator driver.
REQ-011 spike_ch  output  clog2(NCH)  channel index of the current spike_out.
REQ-012 pending_any  output  1  high when any pending counter is nonzero.
REQ-013 ovf  output  NCH  sticky per-channel counter overflow flags.

Function
REQ-014 Each edge with spike_req[i]=1 SHALL increment cnt[i], saturating at 2^CNT_W-1.
REQ-015 A request arriving while cnt[i] is saturated and not decremented that edge SHALL set ovf[i] and drop the spike.
REQ-016 Increment and decrement of the same channel on one edge SHALL leave cnt[i] unchanged and SHALL NOT set ovf[i], including at saturation.
REQ-017 FSM states SHALL be IDLE, FIRE, GAP.
REQ-018 IDLE->FIRE SHALL occur when enable=1, drv_ready=1 and pending_any=1; otherwise IDLE holds.
REQ-019 On the IDLE->FIRE edge, sel SHALL be chosen round-robin: first nonzero cnt at or after ptr, wrapping modulo NCH.
REQ-020 The same edge SHALL decrement cnt[sel], register spike_ch=sel, and set ptr=(sel+1) mod NCH.
REQ-021 spike_out SHALL be high exactly while state is FIRE, for one cycle.
REQ-022 FIRE SHALL go to GAP when GAP>0, otherwise to IDLE.
REQ-023 GAP SHALL last exactly GAP cycles, then return to IDLE, regardless of enable or drv_ready.
REQ-024 spike_ch SHALL hold its last value outside FIRE.
REQ-025 Latency: a request sampled at edge k into an empty, idle, enabled scheduler SHALL produce spike_out in the cycle following edge k+1.
REQ-026 Peak throughput SHALL be one spike per GAP+2 cycles.
REQ-027 pending_any SHALL be the combinational OR of (cnt[i]!=0) from registered counts.
REQ-028 ovf_clr SHALL clear ovf; a new overflow on the same edge SHALL win (flag stays set).
REQ-029 Dropping enable or drv_ready SHALL NOT affect an in-progress FIRE or GAP.

Reset
REQ-030 rst SHALL force state=IDLE, all cnt=0, ptr=0, spike_out=0, spike_ch=0, ovf=0, GAP counter=0.
REQ-031 Assertion of rst mid-FIRE or mid-GAP SHALL abort immediately; pending spikes are discarded.
REQ-032 After rst release, the first issue SHALL start round-robin search from channel 0.

Structure
REQ-033 Shared package rpu_act_pkg SHALL hold the FSM state enum and the default NCH/CNT_W/GAP constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module spike_rr_pick (inputs: nonzero mask, ptr; outputs: sel, valid).
REQ-035 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-036 Single req ch2 at edge 5, enable=1, drv_ready=1 -> spike_out high in cycle after edge 6, spike_ch=2, then 2 GAP cycles, pending_any=0.
REQ-037 spike_req=4'b1111 for one edge -> spikes on ch 0,1,2,3 in order, spaced 4 cycles apart.
REQ-038 20 consecutive pulses on ch1 with enable=0 -> cnt[1]=15, ovf[1]=1 after the 16th pulse; enable=1 -> exactly 15 spikes on ch1.
REQ-039 drv_ready=0 with pending on ch0 -> no spike_out; drv_ready=1 -> spike on ch0 next cycle; drop drv_ready during GAP -> GAP still completes.
REQ-040 cnt[3]=15, req ch3 on the same edge ch3 is issued -> cnt[3]=15, ovf[3]=0; ovf_clr with simultaneous overflow -> ovf stays 1.
REQ-041 rst asserted during GAP with cnt[0]=5 -> spike_out=0, all cnt=0, next grant searches from ch0.

Source files
------------

// File: rtl/rpu_act_pkg.sv
// Shared types and default sizing for the actuator spike scheduler.
// Holds the scheduler FSM encoding and the channel-index width helper.
package rpu_act_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2
    } act_state_t;

    // A single-channel build still needs a 1-bit index
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_rr_pick.sv
// Round-robin picker: first set bit of nz_mask at or after ptr, wrapping.
// Purely combinational, zero latency, no flow control of its own.
module spike_rr_pick
    import rpu_act_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic [NCH-1:0]        nz_mask,
    input  logic [idx_w(NCH)-1:0] ptr,
    output logic [idx_w(NCH)-1:0] sel,
    output logic                  valid
);

    localparam int IDX_W = idx_w(NCH);

    logic [IDX_W-1:0] cand;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NCH);
            if (!valid && nz_mask[cand]) begin
                valid = 1'b1;
                sel   = cand;
            end
        end
    end

endmodule

// File: rtl/actuator_spike_scheduler.sv
// Counts per-channel spike requests and serialises them round-robin onto one actuator driver.
// Request to spike_out: 2 edges when idle; issue waits on enable & drv_ready, FIRE/GAP never stall.
module actuator_spike_scheduler
    import rpu_act_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        spike_req,
    input  logic                  enable,
    input  logic                  drv_ready,
    input  logic                  ovf_clr,
    output logic                  spike_out,
    output logic [idx_w(NCH)-1:0] spike_ch,
    output logic                  pending_any,
    output logic [NCH-1:0]        ovf
);

    localparam int               IDX_W    = idx_w(NCH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    act_state_t       state;
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   nz;
    logic [NCH-1:0]   dec;
    logic [NCH-1:0]   ovf_set;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic             sel_vld;
    logic             issue;
    logic [GAP_W-1:0] gap_cnt;

    always_comb begin
        nz = '0;
        for (int i = 0; i < NCH; i++) begin
            nz[i] = (cnt[i] != '0);
        end
    end

    assign pending_any = |nz;

    spike_rr_pick #(
        .NCH(NCH)
    ) u_pick (
        .nz_mask(nz),
        .ptr    (ptr),
        .sel    (sel),
        .valid  (sel_vld)
    );

    assign issue = (state == ST_IDLE) && enable && drv_ready && sel_vld;

    // A simultaneous request and grant on one channel cancel, so a full counter never overflows then
    always_comb begin
        dec     = '0;
        ovf_set = '0;
        if (issue) begin
            dec[sel] = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            ovf_set[i] = spike_req[i] && !dec[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (spike_req[i] && !dec[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec[i] && !spike_req[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // A fresh overflow outranks a clear arriving on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            spike_out <= 1'b0;
            spike_ch  <= '0;
            ptr       <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state     <= ST_FIRE;
                        spike_out <= 1'b1;
                        spike_ch  <= sel;
                        ptr       <= (int'(sel) == NCH - 1) ? '0 : sel + IDX_W'(1);
                    end
                end
                ST_FIRE: begin
                    spike_out <= 1'b0;
                    if (GAP > 0) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    spike_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_actuator_spike_scheduler.sv
// Directed bench for actuator_spike_scheduler with an expected-channel scoreboard.
module tb_actuator_spike_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] spike_req;
    logic       enable;
    logic       drv_ready;
    logic       ovf_clr;
    logic       spike_out;
    logic [1:0] spike_ch;
    logic       pending_any;
    logic [3:0] ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_spk = 0;
    int exp_q[$];
    int spk_cyc[$];
    int t0;
    int f;

    always #5 clk = ~clk;

    actuator_spike_scheduler #(
        .NCH  (4),
        .CNT_W(4),
        .GAP  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_req  (spike_req),
        .enable     (enable),
        .drv_ready  (drv_ready),
        .ovf_clr    (ovf_clr),
        .spike_out  (spike_out),
        .spike_ch   (spike_ch),
        .pending_any(pending_any),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge and score any spike seen
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (spike_out === 1'b1) begin
            int e;
            e = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_spk++;
            spk_cyc.push_back(cyc);
            chk("spike_ch", 32'(spike_ch), e);
        end else if (spike_out !== 1'b0) begin
            chk("spike_out_known", 32'(spike_out), 0);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        spike_req = '0;
        enable    = 1'b0;
        drv_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        n_spk = 0;
        spk_cyc.delete();
    endtask

    initial begin
        rst       = 1'b1;
        spike_req = '0;
        enable    = 1'b0;
        drv_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        chk("rst_spike_out", 32'(spike_out), 0);
        chk("rst_spike_ch", 32'(spike_ch), 0);
        chk("rst_pending", 32'(pending_any), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // Single request on ch2: two-edge latency, then two quiet gap cycles
        enable    = 1'b1;
        drv_ready = 1'b1;
        tick();
        spike_req = 4'b0100;
        exp_q.push_back(2);
        tick();
        spike_req = '0;
        chk("t1_pending", 32'(pending_any), 1);
        chk("t1_early", 32'(spike_out), 0);
        tick();
        chk("t1_fire", 32'(spike_out), 1);
        chk("t1_pending0", 32'(pending_any), 0);
        tick();
        chk("t1_gap1", 32'(spike_out), 0);
        tick();
        chk("t1_gap2", 32'(spike_out), 0);
        chk("t1_count", 32'(n_spk), 1);
        chk("t1_drained", 32'(exp_q.size()), 0);

        // All four channels at once from reset: 0,1,2,3 spaced GAP+2
        do_reset();
        enable    = 1'b1;
        drv_ready = 1'b1;
        spike_req = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        t0 = cyc;
        tick();
        spike_req = '0;
        repeat (16) tick();
        chk("t2_count", 32'(n_spk), 4);
        chk("t2_drained", 32'(exp_q.size()), 0);
        if (spk_cyc.size() == 4) begin
            chk("t2_first", 32'(spk_cyc[0] - t0), 2);
            for (int k = 1; k < 4; k++) chk("t2_space", 32'(spk_cyc[k] - spk_cyc[k-1]), 4);
        end

        // 20 pulses on ch1 while disabled: saturate at 15, overflow on the 16th
        do_reset();
        drv_ready = 1'b1;
        spike_req = 4'b0010;
        repeat (15) tick();
        chk("t3_ovf_pre", 32'(ovf), 0);
        tick();
        chk("t3_ovf_set", 32'(ovf), 4'b0010);
        repeat (4) tick();
        spike_req = '0;
        chk("t3_pending", 32'(pending_any), 1);
        chk("t3_disabled", 32'(n_spk), 0);
        enable = 1'b1;
        repeat (15) exp_q.push_back(1);
        repeat (64) tick();
        chk("t3_count", 32'(n_spk), 15);
        chk("t3_drained", 32'(exp_q.size()), 0);
        chk("t3_pending0", 32'(pending_any), 0);
        chk("t3_ovf_sticky", 32'(ovf), 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 0);

        // drv_ready low blocks issue; dropping it during GAP does not stretch GAP
        do_reset();
        enable    = 1'b1;
        spike_req = 4'b0001;
        exp_q.push_back(0);
        tick();
        spike_req = '0;
        repeat (5) tick();
        chk("t4_blocked", 32'(n_spk), 0);
        chk("t4_pending", 32'(pending_any), 1);
        drv_ready = 1'b1;
        tick();
        chk("t4_fire", 32'(spike_out), 1);
        f         = cyc;
        drv_ready = 1'b0;
        spike_req = 4'b0001;
        exp_q.push_back(0);
        tick();
        spike_req = '0;
        tick();
        drv_ready = 1'b1;
        tick();
        tick();
        chk("t4_refire", 32'(spike_out), 1);
        chk("t4_spacing", (spk_cyc.size() == 2) ? 32'(spk_cyc[1] - f) : 32'hffff_ffff, 4);
        repeat (4) tick();
        chk("t4_drained", 32'(exp_q.size()), 0);

        // Saturated ch3: request on its grant edge holds 15 without overflow
        do_reset();
        drv_ready = 1'b1;
        spike_req = 4'b1000;
        repeat (15) tick();
        chk("t5_ovf_pre", 32'(ovf), 0);
        enable = 1'b1;
        exp_q.push_back(3);
        tick();
        chk("t5_fire", 32'(spike_out), 1);
        chk("t5_no_ovf", 32'(ovf), 0);
        tick();
        chk("t5_ovf_set", 32'(ovf), 4'b1000);
        ovf_clr = 1'b1;
        tick();
        chk("t5_ovf_wins", 32'(ovf), 4'b1000);
        spike_req = '0;
        tick();
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", 32'(ovf), 0);
        repeat (15) exp_q.push_back(3);
        repeat (64) tick();
        chk("t5_count", 32'(n_spk), 16);
        chk("t5_drained", 32'(exp_q.size()), 0);
        chk("t5_pending0", 32'(pending_any), 0);

        // Reset in GAP with cnt[0]=5 and ptr=1: everything cleared, search restarts at ch0
        do_reset();
        drv_ready = 1'b1;
        spike_req = 4'b0001;
        repeat (5) tick();
        spike_req = '0;
        enable    = 1'b1;
        exp_q.push_back(0);
        tick();
        chk("t6_fire", 32'(spike_out), 1);
        spike_req = 4'b0001;
        tick();
        spike_req = '0;
        rst       = 1'b1;
        #1;
        chk("t6_rst_spike", 32'(spike_out), 0);
        chk("t6_rst_pending", 32'(pending_any), 0);
        chk("t6_rst_ch", 32'(spike_ch), 0);
        tick();
        rst = 1'b0;
        chk("t6_post_pending", 32'(pending_any), 0);
        spike_req = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        spike_req = '0;
        repeat (10) tick();
        chk("t6_count", 32'(n_spk), 3);
        chk("t6_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
